// File: rtl/alu_lockstep_sched_if.sv
// Bundle of requester, ALU-pair and response signals around the lockstep scheduler.
// The slave view belongs to the scheduler; the master view belongs to the surrounding glue/ALU pair.
interface alu_lockstep_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [1:0] req0_sel;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [1:0] req1_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_out1;
    logic [7:0] alu_out2;
    logic       carry1;
    logic       carry2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_err;
    logic [7:0] mismatch_cnt;
    logic       busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  alu_out1, alu_out2, carry1, carry2, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, mismatch_cnt, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output alu_out1, alu_out2, carry1, carry2, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, mismatch_cnt, busy
    );
endinterface

// File: rtl/alu_lockstep_sched.sv
// Round-robin scheduler feeding identical operands to a duplicated ALU, comparing both
// copies after a fixed latency and re-executing on disagreement until retries run out.
module alu_lockstep_sched #(
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_lockstep_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, CHECK, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t     state_q;
    logic       rr_ptr_q;
    logic       id_q;
    logic [2:0] retry_q;
    logic [3:0] wait_q;
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [1:0] alu_sel_q;
    logic [7:0] result_q;
    logic       carry_q;
    logic       err_q;
    logic [7:0] mismatch_q;

    logic       grant_valid;
    logic       grant_id;
    logic       lanes_equal;
    logic [7:0] mismatch_d;

    // A lone requester always wins; rr_ptr only breaks ties.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
        lanes_equal = ({bus.alu_out1, bus.carry1} == {bus.alu_out2, bus.carry2});
        mismatch_d  = (mismatch_q == 8'hFF) ? mismatch_q : mismatch_q + 8'd1;
    end

    assign bus.req0_ready   = (state_q == IDLE) && grant_valid && !grant_id;
    assign bus.req1_ready   = (state_q == IDLE) && grant_valid && grant_id;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_sel      = alu_sel_q;
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_carry    = carry_q;
    assign bus.rsp_err      = err_q;
    assign bus.mismatch_cnt = mismatch_q;
    assign bus.busy         = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            id_q       <= 1'b0;
            retry_q    <= '0;
            wait_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            mismatch_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        alu_a_q   <= grant_id ? bus.req1_a   : bus.req0_a;
                        alu_b_q   <= grant_id ? bus.req1_b   : bus.req0_b;
                        alu_sel_q <= grant_id ? bus.req1_sel : bus.req0_sel;
                        id_q      <= grant_id;
                        retry_q   <= '0;
                        wait_q    <= WAIT_INIT;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (wait_q == 4'd0) begin
                        state_q <= CHECK;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                CHECK: begin
                    // On final disagreement ALU1 is still reported, flagged as untrusted.
                    if (lanes_equal) begin
                        result_q <= bus.alu_out1;
                        carry_q  <= bus.carry1;
                        err_q    <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        mismatch_q <= mismatch_d;
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 3'd1;
                            wait_q  <= WAIT_INIT;
                            state_q <= EXEC;
                        end else begin
                            result_q <= bus.alu_out1;
                            carry_q  <= bus.carry1;
                            err_q    <= 1'b1;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rr_ptr_q <= ~id_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_lockstep_sched.sv
// Scoreboard bench for alu_lockstep_sched: directed ops push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_lockstep_sched;
    typedef struct {
        logic       id;
        logic [7:0] result;
        logic       carry;
        logic       err;
        logic [7:0] mm;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   faultMode = 0;
    int   grantCycle = 0;
    logic rspSeen = 1'b0;
    exp_t expQ[$];
    exp_t popped;
    logic [8:0] alu1;

    alu_lockstep_sched_if bus();

    alu_lockstep_sched #(.ALU_LAT(1), .MAX_RETRY(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [8:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        case (sel)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a < b), a - b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Mode 1 corrupts ALU2 only until the first mismatch is counted; mode 2 sticks it at zero.
    always_comb alu1 = aluModel(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_out1 = alu1[7:0];
    assign bus.carry1   = alu1[8];
    assign bus.carry2   = alu1[8];
    assign bus.alu_out2 = (faultMode == 2) ? 8'h00 :
                          ((faultMode == 1) && (bus.mismatch_cnt == 8'h00)) ? ~alu1[7:0] : alu1[7:0];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: latency on first rsp_valid, field checks on the handshake.
    always @(negedge clk) begin
        if (bus.req0_ready || bus.req1_ready) grantCycle = cycle;
        if (!rst && bus.rsp_valid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid with id %0d, expected no response", bus.rsp_id);
            end else begin
                if (!rspSeen) begin
                    rspSeen = 1'b1;
                    checkOutput("latency", cycle - grantCycle, expQ[0].lat);
                end
                if (bus.rsp_ready) begin
                    popped = expQ.pop_front();
                    rspSeen = 1'b0;
                    checkOutput("rsp_id", bus.rsp_id, popped.id);
                    checkOutput("rsp_result", bus.rsp_result, popped.result);
                    checkOutput("rsp_carry", bus.rsp_carry, popped.carry);
                    checkOutput("rsp_err", bus.rsp_err, popped.err);
                    checkOutput("mismatch_cnt", bus.mismatch_cnt, popped.mm);
                end
            end
        end
    end

    task automatic pushExp(input logic id, input logic [7:0] res, input logic c, input logic err,
                           input logic [7:0] mm, input int lat);
        exp_t e;
        e.id = id; e.result = res; e.carry = c; e.err = err; e.mm = mm; e.lat = lat;
        expQ.push_back(e);
    endtask

    task automatic driveReq(input logic id, input logic valid, input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        if (id) begin
            bus.req1_valid = valid; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
        end else begin
            bus.req0_valid = valid; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
        end
    endtask

    task automatic waitGrant(input logic id, input string name);
        logic got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
        end
        checkOutput(name, got, 1);
    endtask

    task automatic waitDrain();
        logic done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (expQ.size() == 0);
        end
        checkOutput("drain", done, 1);
    endtask

    task automatic applyStimulus(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                                 input logic [7:0] res, input logic c, input logic err,
                                 input logic [7:0] mm, input int lat);
        pushExp(id, res, c, err, mm, lat);
        @(posedge clk); #1;
        driveReq(id, 1'b1, a, b, sel);
        waitGrant(id, "grant");
        @(posedge clk); #1;
        driveReq(id, 1'b0, a, b, sel);
        waitDrain();
    endtask

    initial begin
        int grants;
        logic [7:0] mmExp;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        driveReq(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
        driveReq(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        checkOutput("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry,
                                bus.rsp_err, bus.mismatch_cnt, bus.busy}, 0);

        // Fairness: both requesters held valid for four grants.
        pushExp(1'b0, 8'h02, 1'b1, 1'b0, 8'h00, 3);
        pushExp(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 3);
        pushExp(1'b0, 8'h02, 1'b1, 1'b0, 8'h00, 3);
        pushExp(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 3);
        @(posedge clk); #1;
        driveReq(1'b0, 1'b1, 8'h81, 8'h81, 2'b00);
        driveReq(1'b1, 1'b1, 8'h0F, 8'h01, 2'b00);
        grants = 0;
        for (int i = 0; i < 200 && grants < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) grants++;
        end
        @(posedge clk); #1;
        driveReq(1'b0, 1'b0, 8'h81, 8'h81, 2'b00);
        driveReq(1'b1, 1'b0, 8'h0F, 8'h01, 2'b00);
        checkOutput("fair_grants", grants, 4);
        waitDrain();

        applyStimulus(1'b0, 8'h81, 8'h81, 2'b00, 8'h02, 1'b1, 1'b0, 8'h00, 3);

        // Transient fault on the first CHECK only: one retry.
        faultMode = 1;
        applyStimulus(1'b0, 8'h10, 8'h05, 2'b01, 8'h0B, 1'b0, 1'b0, 8'h01, 5);
        faultMode = 0;

        // Backpressure: response parked while req1 waits.
        bus.rsp_ready = 1'b0;
        pushExp(1'b0, 8'h03, 1'b0, 1'b0, 8'h01, 3);
        pushExp(1'b1, 8'h10, 1'b0, 1'b0, 8'h01, 3);
        @(posedge clk); #1;
        driveReq(1'b0, 1'b1, 8'h01, 8'h02, 2'b11);
        waitGrant(1'b0, "bp_grant0");
        @(posedge clk); #1;
        driveReq(1'b0, 1'b0, 8'h01, 8'h02, 2'b11);
        driveReq(1'b1, 1'b1, 8'h0F, 8'h01, 2'b00);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_req1_ready", bus.req1_ready, 0);
            checkOutput("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_err},
                        {1'b1, 1'b0, 8'h03, 1'b0, 1'b0});
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_no_same_cycle_grant", bus.req1_ready, 0);
        @(negedge clk);
        checkOutput("bp_grant_next", bus.req1_ready, 1);
        @(posedge clk); #1;
        driveReq(1'b1, 1'b0, 8'h0F, 8'h01, 2'b00);
        waitDrain();

        // Permanent fault: three mismatches per op, counter saturates.
        faultMode = 2;
        applyStimulus(1'b1, 8'h3C, 8'h0F, 2'b10, 8'h0C, 1'b0, 1'b1, 8'h04, 7);
        for (int k = 1; k <= 100; k++) begin
            mmExp = (4 + 3 * k > 255) ? 8'hFF : 8'(4 + 3 * k);
            applyStimulus(1'b0, 8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b1, mmExp, 7);
        end
        faultMode = 0;

        // Reset during EXEC aborts the op; pending req1 is granted right after.
        @(posedge clk); #1;
        driveReq(1'b0, 1'b1, 8'hAA, 8'h55, 2'b11);
        waitGrant(1'b0, "rst_op_grant");
        @(posedge clk); #1;
        rst = 1'b1;
        driveReq(1'b0, 1'b0, 8'hAA, 8'h55, 2'b11);
        driveReq(1'b1, 1'b1, 8'h0F, 8'h01, 2'b00);
        pushExp(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 3);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        checkOutput("midrst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry,
                                   bus.rsp_err, bus.mismatch_cnt, bus.busy}, 0);
        checkOutput("midrst_req1_grant", bus.req1_ready, 1);
        @(posedge clk); #1;
        driveReq(1'b1, 1'b0, 8'h0F, 8'h01, 2'b00);
        waitDrain();

        checkOutput("queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
